lcd12864_rx: RTL
================

Name: lcd12864_rx

Overview:
- Slave/receiver end of the ST7920-style LCD12864 8-bit parallel write bus, i.e. the panel side of what our LCD driver blocks talk to.
- Samples rs/rw/en/dat and decodes the basic instruction set.
- Keeps a 64-byte DDRAM shadow, address counter and display-control state, and exposes them to on-chip logic for self-check and screen mirroring.
- Sits on the same FPGA as a bus monitor or loopback target for driver verification.

Parameters:
SYNC_STAGES, 2, synchronizer depth on lcd_* inputs (min 2)
BUSY_CYC, 16, clk cycles busy is held after an accepted non-clear byte
CLR_CYC, 64, clk cycles busy is held after clear (min 64; fill takes 64)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
lcd_rs  in  1  0=instruction, 1=data
lcd_rw  in  1  0=write; 1=read (ignored)
lcd_en  in  1  strobe; byte latched on falling edge
lcd_dat  in  8  bus data
rd_addr  in  6  shadow read address, byte index
rd_data  out  8  shadow byte, registered, 1-cycle latency
cmd_stb  out  1  1-cycle pulse per accepted instruction
cmd_byte  out  8  last accepted instruction, valid with cmd_stb
wr_stb  out  1  1-cycle pulse per DDRAM data write
wr_addr  out  6  byte index written, valid with wr_stb
wr_data  out  8  byte written, valid with wr_stb
addr_cnt  out  6  current byte address {word[4:0],half}
busy  out  1  emulated busy flag
display_on, cursor_on, blink_on  out  1 each  display control bits
overrun_err  out  1  sticky: falling edge accepted while busy
unsup_err  out  1  sticky: unsupported instruction seen

Behaviour:
- Reset, async: all outputs 0; addr_cnt=0; inc_mode=1; ext_mode=0; shadow contents undefined until first clear.
- Input path: rs/rw/en/dat pass through SYNC_STAGES flops. A falling edge on synchronized en (prev 1, now 0) captures the rs/rw/dat values from the same stage. Latency from the en pin falling to a strobe is SYNC_STAGES+1 clk.
- rw=1 edges: ignored, no state change.
- Edge while busy=1: byte dropped, overrun_err set. Busy is not extended.
- Accepted rs=0 byte: cmd_stb pulses. Decode (RE=0):
  - 0x01: clear, fills bytes 0..63 with 0x20, one byte per clk starting the cycle after cmd_stb; then addr_cnt=0, inc_mode=1. Busy = max(64, CLR_CYC).
  - 0x02/0x03: home, addr_cnt=0.
  - 0x04-0x07: inc_mode = dat[1].
  - 0x08-0x0F: display_on=dat[2], cursor_on=dat[1], blink_on=dat[0].
  - 0x10-0x1F: if dat[3]=0, cursor step of addr_cnt in direction dat[2] (1=+1 byte), wraps mod 64. dat[3]=1 is a no-op.
  - 0x20-0x3F: ext_mode=dat[2]; DL is ignored.
  - 0x40-0x7F: unsup_err set, otherwise ignored.
  - 0x80-0xFF: word=dat[4:0], half=0. dat[6:5] ignored.
- With ext_mode=1, every instruction other than function set raises unsup_err and is ignored.
- Accepted rs=1 byte:
  - Writes shadow[addr_cnt]; wr_stb/wr_addr/wr_data report it.
  - inc_mode=1: addr_cnt+1 mod 64.
  - inc_mode=0: addr_cnt-1 mod 64.
- Busy: rises the cycle after any accepted byte and holds BUSY_CYC clk, CLR_CYC for clear.
- Shadow: single write port (decoder or clear fill) plus independent read port. A same-cycle read and write to one address returns the old value.
- Reset mid-clear aborts the fill; busy=0 immediately.

Test Plan:
- Write 0x31,0x0C,0x06,0x01, then data 0xCE,0xD2 -> display_on=1, cursor_on=0, blink_on=0; after clear, shadow[2..63]=0x20; shadow[0]=0xCE, shadow[1]=0xD2; addr_cnt=2; three cmd_stb and two wr_stb pulses in total besides clear.
- Instr 0x90, then data 0xEE,0xA3,0xD6 -> wr_addr 32,33,34; addr_cnt=35.
- Instr 0x9F, data 0x41,0x42,0x43 -> written at 62,63,0; addr_cnt=1 (wrap).
- Instr 0x04, 0x80, data 0x55 -> written at 0; addr_cnt=63.
- Send data byte 3 clk after a prior accepted byte (BUSY_CYC=16) -> dropped, overrun_err=1, shadow unchanged. Then instr 0x34 followed by 0x0C -> unsup_err=1, display_on unchanged.
- Instr 0x01; assert rst_n=0 at fill cycle 20 -> busy=0 and all flags 0 asynchronously. Bytes 20..63 keep their prior values.
- Toggle lcd_en with lcd_rw=1 and random dat -> no strobes, no state change.

Source files
------------

// File: rtl/lcd12864_rx.sv
`default_nettype none
// ============================================================================
// Module   : lcd12864_rx
// Brief    : Panel-side receiver for the ST7920-style LCD12864 8-bit parallel
//            write bus. Decodes the basic instruction set and keeps a 64-byte
//            DDRAM shadow, address counter and display-control state.
// Revision : 1.0 - initial release
// ============================================================================
module lcd12864_rx #(
  parameter int SYNC_STAGES = 2,   // input synchronizer depth (>= 2)
  parameter int BUSY_CYC    = 16,  // busy hold after a normal byte
  parameter int CLR_CYC     = 64   // busy hold after clear (>= 64)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_dat,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_stb,
  output logic [7:0] cmd_byte,
  output logic       wr_stb,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [5:0] addr_cnt,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       overrun_err,
  output logic       unsup_err
);

  // The clear fill needs 64 cycles, so busy after clear never drops below that.
  localparam int CLR_TOT = (CLR_CYC < 64) ? 64 : CLR_CYC;
  localparam int CNT_MAX = (CLR_TOT > BUSY_CYC) ? CLR_TOT : BUSY_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  // Synchronizer word layout: {rs, rw, en, dat[7:0]}
  logic [10:0] sync_q [SYNC_STAGES];
  logic        en_prev_q;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]  fill_q, fill_d;      // bit 6 set once all 64 bytes are filled
  logic [5:0]  addr_q, addr_d;
  logic        inc_q, inc_d;
  logic        ext_q, ext_d;
  logic        disp_q, disp_d;
  logic        cur_q, cur_d;
  logic        blink_q, blink_d;
  logic        ovr_q, ovr_d;
  logic        unsup_q, unsup_d;
  logic        cmd_stb_q, cmd_stb_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        wr_stb_q, wr_stb_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_data_q;

  logic [7:0]  mem_q [64];
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  logic        s_rs, s_rw, s_en;
  logic [7:0]  s_dat;
  logic        fall, take, drop;

  assign s_rs  = sync_q[SYNC_STAGES-1][10];
  assign s_rw  = sync_q[SYNC_STAGES-1][9];
  assign s_en  = sync_q[SYNC_STAGES-1][8];
  assign s_dat = sync_q[SYNC_STAGES-1][7:0];

  // rw=1 strobes are reads from the panel and are ignored entirely.
  assign fall = en_prev_q & ~s_en & ~s_rw;
  assign take = fall & (state_q == ST_IDLE);
  assign drop = fall & (state_q != ST_IDLE);

  // Bring the asynchronous bus into the clk domain and remember the last en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_rs, lcd_rw, lcd_en, lcd_dat};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_prev_q <= s_en;
    end
  end

  // Decode accepted bytes, sequence busy/clear, and drive the shadow write port.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    ext_d      = ext_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    ovr_d      = ovr_q;
    unsup_d    = unsup_q;
    cmd_stb_d  = 1'b0;
    cmd_byte_d = cmd_byte_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = s_dat;

    case (state_q)
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      ST_FILL: begin
        cnt_d = cnt_q - CW'(1);
        if (!fill_q[6]) begin
          mem_we    = 1'b1;
          mem_waddr = fill_q[5:0];
          mem_wdata = 8'h20;
          fill_d    = fill_q + 7'd1;
          if (fill_q[5:0] == 6'd63) begin
            addr_d = 6'd0;
            inc_d  = 1'b1;
          end
        end
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (drop) ovr_d = 1'b1;

    if (take) begin
      state_d = ST_BUSY;
      cnt_d   = CW'(BUSY_CYC);
      if (s_rs) begin
        mem_we    = 1'b1;
        wr_stb_d  = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = s_dat;
        addr_d    = inc_q ? addr_q + 6'd1 : addr_q - 6'd1;
      end else begin
        cmd_stb_d  = 1'b1;
        cmd_byte_d = s_dat;
        if (ext_q && (s_dat[7:5] != 3'b001)) begin
          // Extended set is not emulated; only function set may leave it.
          unsup_d = 1'b1;
        end else if (s_dat == 8'h01) begin
          state_d = ST_FILL;
          cnt_d   = CW'(CLR_TOT);
          fill_d  = 7'd0;
        end else if (s_dat[7:1] == 7'b0000001) begin
          addr_d = 6'd0;
        end else if (s_dat[7:2] == 6'b000001) begin
          inc_d = s_dat[1];
        end else if (s_dat[7:3] == 5'b00001) begin
          disp_d  = s_dat[2];
          cur_d   = s_dat[1];
          blink_d = s_dat[0];
        end else if (s_dat[7:4] == 4'b0001) begin
          if (!s_dat[3]) addr_d = s_dat[2] ? addr_q + 6'd1 : addr_q - 6'd1;
        end else if (s_dat[7:5] == 3'b001) begin
          ext_d = s_dat[2];
        end else if (s_dat[7:6] == 2'b01) begin
          unsup_d = 1'b1;
        end else if (s_dat[7]) begin
          addr_d = {s_dat[4:0], 1'b0};
        end
      end
    end
  end

  // Control state register; reset aborts any clear fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_q     <= 7'h40;
      addr_q     <= 6'd0;
      inc_q      <= 1'b1;
      ext_q      <= 1'b0;
      disp_q     <= 1'b0;
      cur_q      <= 1'b0;
      blink_q    <= 1'b0;
      ovr_q      <= 1'b0;
      unsup_q    <= 1'b0;
      cmd_stb_q  <= 1'b0;
      cmd_byte_q <= 8'h00;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= 8'h00;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      ext_q      <= ext_d;
      disp_q     <= disp_d;
      cur_q      <= cur_d;
      blink_q    <= blink_d;
      ovr_q      <= ovr_d;
      unsup_q    <= unsup_d;
      cmd_stb_q  <= cmd_stb_d;
      cmd_byte_q <= cmd_byte_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= mem_q[rd_addr];
    end
  end

  // Shadow RAM write port; contents are not reset (undefined until a clear).
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data     = rd_data_q;
  assign cmd_stb     = cmd_stb_q;
  assign cmd_byte    = cmd_byte_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign addr_cnt    = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign display_on  = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign overrun_err = ovr_q;
  assign unsup_err   = unsup_q;

endmodule
`default_nettype wire
